// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - LEGv8 multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT)
// Optional perf counters behind `MULTICYCLE_SEQ_PERF_CNT_EN.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             negative,
  input  logic             overflow,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             instr_done,
  output logic             halted,
  output logic             mem_err,
`ifdef MULTICYCLE_SEQ_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
`endif
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_NOP, C_ALU, C_LDUR, C_STUR, C_B, C_CBZ, C_BLT
  } class_e;

  // One spare bit lets the compare see MEM_TIMEOUT itself without wrapping.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W:0] TIMEOUT_V = (WAIT_W + 1)'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  class_e            class_q, class_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W:0]   wait_inc;
  logic              halted_q, halted_d;
  logic              mem_err_q, mem_err_d;

  logic ir_c, pw_c, ps_c, rw_c, mr_c, mw_c, done_c;

  function automatic class_e decode_class(input logic [10:0] op);
    casez (op)
      11'b10101011000,
      11'b11101011000,
      11'b1001000100?,
      11'b11010011011,
      11'b11010011010: decode_class = C_ALU;
      11'b11111000010: decode_class = C_LDUR;
      11'b11111000000: decode_class = C_STUR;
      11'b000101?????: decode_class = C_B;
      11'b10110100???: decode_class = C_CBZ;
      11'b01010100???: decode_class = C_BLT;
      default:         decode_class = C_NOP;
    endcase
  endfunction

  assign wait_inc = {1'b0, wait_q} + (WAIT_W + 1)'(1);

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    wait_d    = wait_q;
    halted_d  = halted_q;
    mem_err_d = mem_err_q;
    ir_c      = 1'b0;
    pw_c      = 1'b0;
    ps_c      = 1'b0;
    rw_c      = 1'b0;
    mr_c      = 1'b0;
    mw_c      = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_c    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        class_d = decode_class(opcode);
        if (class_d == C_NOP) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          C_ALU: state_d = S_WB;
          C_LDUR, C_STUR: begin
            state_d = S_MEM;
            wait_d  = '0;
          end
          C_B, C_CBZ, C_BLT: begin
            pw_c    = 1'b1;
            done_c  = 1'b1;
            state_d = S_FETCH;
            if (class_q == C_B)        ps_c = 1'b1;
            else if (class_q == C_CBZ) ps_c = zero;
            else                       ps_c = negative ^ overflow;
          end
          default: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mr_c = (class_q == C_LDUR);
        mw_c = (class_q == C_STUR);
        if (mem_ready) begin
          if (class_q == C_LDUR) begin
            state_d = S_WB;
          end else begin
            pw_c    = 1'b1;
            done_c  = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          wait_d = wait_inc[WAIT_W-1:0];
          if (MEM_TIMEOUT != 0 && wait_inc == TIMEOUT_V) begin
            state_d   = S_HALT;
            halted_d  = 1'b1;
            mem_err_d = 1'b1;
          end
        end
      end
      S_WB: begin
        rw_c    = 1'b1;
        pw_c    = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: halted_d = 1'b1;
      default: begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      class_q   <= C_NOP;
      wait_q    <= '0;
      halted_q  <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wait_q    <= wait_d;
      halted_q  <= halted_d;
      mem_err_q <= mem_err_d;
    end
  end

`ifdef MULTICYCLE_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else if (state_q != S_HALT) begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (done_c) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_count = cycle_cnt_q;
  assign instr_count = instr_cnt_q;
`endif

  // Reset masks every strobe so nothing is written in the cycle rst is held.
  assign ir_write   = ir_c   & ~rst;
  assign pc_write   = pw_c   & ~rst;
  assign pc_sel     = ps_c   & ~rst;
  assign reg_write  = rw_c   & ~rst;
  assign mem_read   = mr_c   & ~rst;
  assign mem_write  = mw_c   & ~rst;
  assign instr_done = done_c & ~rst;
  assign halted     = halted_q;
  assign mem_err    = mem_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_BLT  = 11'b01010100000;
  localparam logic [10:0] OP_BAD  = 11'b00000000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] opcode = '0;
  logic        zero = 1'b0, negative = 1'b0, overflow = 1'b0, mem_ready = 1'b0;
  logic        ir_write, pc_write, pc_sel, reg_write, mem_read, mem_write, instr_done;
  logic        halted, mem_err;
  logic [2:0]  state;
`ifdef MULTICYCLE_SEQ_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  int checks = 0;
  int errors = 0;

  // {state, ir, pc_write, pc_sel, reg_write, mem_read, mem_write, instr_done}
  logic [9:0] obs;
  assign obs = {state, ir_write, pc_write, pc_sel, reg_write, mem_read, mem_write, instr_done};

  multicycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .negative(negative),
    .overflow(overflow), .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
    .pc_sel(pc_sel), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .instr_done(instr_done), .halted(halted), .mem_err(mem_err),
`ifdef MULTICYCLE_SEQ_PERF_CNT_EN
    .cycle_count(cycle_count), .instr_count(instr_count),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    #3;
    checks++;
    if (obs !== 10'b0 || halted !== 1'b0 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL reset got obs=%b halted=%b mem_err=%b exp obs=0 halted=0 mem_err=0", obs, halted, mem_err);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_adds();
    logic [9:0] exp_t [0:3];
    exp_t = '{{3'd0, 7'b1000000}, {3'd1, 7'b0}, {3'd2, 7'b0}, {3'd4, 7'b0101001}};
    opcode = OP_ADDS;
    for (int i = 0; i < 4; i++) begin
      #3;
      checks++;
      if (obs !== exp_t[i]) begin
        errors++;
        $display("FAIL adds cycle %0d got %b exp %b", i, obs, exp_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_ldur();
    logic [9:0] exp_t [0:7];
    logic       mr_t  [0:7];
    exp_t = '{{3'd0, 7'b1000000}, {3'd1, 7'b0}, {3'd2, 7'b0}, {3'd3, 7'b0000100},
              {3'd3, 7'b0000100}, {3'd3, 7'b0000100}, {3'd3, 7'b0000100}, {3'd4, 7'b0101001}};
    mr_t  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = OP_LDUR;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr_t[i];
      #3;
      checks++;
      if (obs !== exp_t[i]) begin
        errors++;
        $display("FAIL ldur cycle %0d got %b exp %b", i, obs, exp_t[i]);
      end
      tick();
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_branches();
    logic [10:0] op_t [0:5];
    logic [2:0]  fl_t [0:5];
    logic        ps_t [0:5];
    logic [9:0]  exp_v;
    op_t = '{OP_CBZ, OP_CBZ, OP_BLT, OP_BLT, OP_B, OP_BLT};
    fl_t = '{3'b100, 3'b000, 3'b010, 3'b011, 3'b000, 3'b001};  // {zero, negative, overflow}
    ps_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int v = 0; v < 6; v++) begin
      opcode = op_t[v];
      for (int c = 0; c < 3; c++) begin
        // flags are inverted outside EXEC and must not matter there
        {zero, negative, overflow} = (c == 2) ? fl_t[v] : ~fl_t[v];
        exp_v = (c == 0) ? {3'd0, 7'b1000000} :
                (c == 1) ? {3'd1, 7'b0} : {3'd2, 1'b0, 1'b1, ps_t[v], 4'b0001};
        #3;
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL branch vec %0d cycle %0d got %b exp %b", v, c, obs, exp_v);
        end
        tick();
      end
    end
    {zero, negative, overflow} = 3'b000;
  endtask

  task automatic test_stur_timeout();
    logic [9:0] exp_v;
    opcode = OP_STUR;
    mem_ready = 1'b0;
    for (int i = 0; i < 23; i++) begin
      exp_v = (i == 0) ? {3'd0, 7'b1000000} : (i == 1) ? {3'd1, 7'b0} :
              (i == 2) ? {3'd2, 7'b0} : (i < 19) ? {3'd3, 7'b0000010} : {3'd5, 7'b0};
      #3;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stur_timeout cycle %0d got %b exp %b", i, obs, exp_v);
      end
      if (i == 18 || i == 22) begin
        checks++;
        if (halted !== (i == 22) || mem_err !== (i == 22)) begin
          errors++;
          $display("FAIL stur_flags cycle %0d got halted=%b mem_err=%b exp %b", i, halted, mem_err, i == 22);
        end
      end
      tick();
    end
    do_reset();
    #3;
    checks++;
    if (halted !== 1'b0 || mem_err !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL stur_reset_clear got halted=%b mem_err=%b state=%0d exp 0 0 0", halted, mem_err, state);
    end
    #2;
  endtask

  task automatic test_illegal();
    logic [9:0] exp_t [0:4];
    exp_t = '{{3'd0, 7'b1000000}, {3'd1, 7'b0}, {3'd5, 7'b0}, {3'd5, 7'b0}, {3'd5, 7'b0}};
    opcode = OP_BAD;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      checks++;
      if (obs !== exp_t[i]) begin
        errors++;
        $display("FAIL illegal cycle %0d got %b exp %b", i, obs, exp_t[i]);
      end
      tick();
    end
    mem_ready = 1'b0;
    #3;
    checks++;
    if (halted !== 1'b1 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_flags got halted=%b mem_err=%b exp 1 0", halted, mem_err);
    end
    rst = 1'b1;
    tick();
    #3;
    checks++;
    if (state !== 3'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL illegal_reset got state=%0d halted=%b exp 0 0", state, halted);
    end
    #2;
    rst = 1'b0;
    test_adds();
  endtask

  task automatic test_reset_mid();
    opcode = OP_LDUR;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #3;
    checks++;
    if (obs !== {3'd3, 7'b0}) begin
      errors++;
      $display("FAIL reset_mid_hold got %b exp %b", obs, {3'd3, 7'b0});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++;
      if (state !== 3'(i) || reg_write !== 1'b0 || mem_read !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid cycle %0d got state=%0d reg_write=%b mem_read=%b exp %0d 0 0",
                 i, state, reg_write, mem_read, i);
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [10:0] op_t [0:10];
    int n_done;
    int n_pw;
    op_t = '{OP_ADDS, OP_ADDS, OP_ADDS, OP_ADDS, OP_STUR, OP_STUR, OP_STUR, OP_STUR, OP_B, OP_B, OP_B};
    n_done = 0;
    n_pw = 0;
    mem_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      opcode = op_t[i];
      #3;
      if (instr_done === 1'b1) n_done++;
      if (pc_write === 1'b1) n_pw++;
      if (i == 7) begin
        checks++;
        if (obs !== {3'd3, 7'b0100011}) begin
          errors++;
          $display("FAIL b2b_stur got %b exp %b", obs, {3'd3, 7'b0100011});
        end
      end
      tick();
    end
    mem_ready = 1'b0;
    #3;
    checks++;
    if (n_done !== 3 || n_pw !== 3 || state !== 3'd0) begin
      errors++;
      $display("FAIL b2b got done=%0d pc_write=%0d state=%0d exp 3 3 0", n_done, n_pw, state);
    end
    #2;
  endtask

`ifdef MULTICYCLE_SEQ_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    opcode = OP_ADDS;
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (instr_count !== 32'd10 || cycle_count !== 32'd40) begin
      errors++;
      $display("FAIL perf got instr=%0d cycle=%0d exp 10 40", instr_count, cycle_count);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_adds();
    test_ldur();
    test_branches();
    test_stur_timeout();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
`ifdef MULTICYCLE_SEQ_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
